// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction-fetch front end. Owns the PC, issues fetch
// requests on the instruction bus, and buffers returned words with their
// addresses in a small FIFO. The FIFO head feeds the IF/ID register.
// Jumps redirect the PC, flush the buffer and discard in-flight responses.
module ifu_prefetch #(
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [31:0]       RESET_ADDR = 32'h0000_0000,
  parameter int unsigned       HOLD_W     = 3,
  parameter logic [HOLD_W-1:0] HOLD_IF    = HOLD_W'(2),
  parameter logic [31:0]       INST_NOP   = 32'h0000_0013,
  parameter logic [31:0]       ZERO_WORD  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  output logic              ibus_req_o,
  output logic [31:0]       ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [31:0]       ibus_rdata_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_addr_o,
  output logic              inst_valid_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  logic [31:0]      pc_q, pc_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] aq_wr_q, aq_wr_d;
  logic [PTR_W-1:0] aq_rd_q, aq_rd_d;
  logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d;
  logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d;

  logic [31:0] aq_addr_q   [FIFO_DEPTH];
  logic [31:0] fifo_addr_q [FIFO_DEPTH];
  logic [31:0] fifo_inst_q [FIFO_DEPTH];

  logic             hold_if;
  logic             fifo_pop;
  logic             grant;
  logic             resp_known;
  logic             resp_drop;
  logic             resp_take;
  logic [SUM_W-1:0] credits_used;
  logic             jump_addr_unused;

  // The two low target bits are always forced to zero, so they are not needed.
  assign jump_addr_unused = |jump_addr_i[1:0];

  // Handshake decode: pop, credit-based issue, grant and response classification.
  always_comb begin
    hold_if      = (hold_flag_i >= HOLD_IF);
    fifo_pop     = (fifo_cnt_q != '0) && !hold_if && !jump_flag_i;
    credits_used = SUM_W'(out_cnt_q) + SUM_W'(disc_cnt_q) + SUM_W'(fifo_cnt_q)
                 - SUM_W'(fifo_pop);
    ibus_req_o   = run_q && !jump_flag_i && (credits_used < SUM_W'(FIFO_DEPTH));
    grant        = ibus_req_o && ibus_gnt_i;
    resp_known   = ibus_rvalid_i && ((disc_cnt_q != '0) || (out_cnt_q != '0));
    resp_drop    = ibus_rvalid_i && (disc_cnt_q != '0);
    resp_take    = ibus_rvalid_i && (disc_cnt_q == '0) && (out_cnt_q != '0)
                 && !jump_flag_i;
  end

  // Next-state for PC, counters and pointers; a jump overrides everything else.
  always_comb begin
    pc_d       = pc_q;
    run_d      = 1'b1;
    out_cnt_d  = out_cnt_q + CNT_W'(grant) - CNT_W'(resp_take);
    disc_cnt_d = disc_cnt_q - CNT_W'(resp_drop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(resp_take) - CNT_W'(fifo_pop);
    aq_wr_d    = aq_wr_q;
    aq_rd_d    = aq_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    if (grant) begin
      pc_d    = pc_q + 32'd4;
      aq_wr_d = aq_wr_q + PTR_W'(1);
    end
    if (resp_take) begin
      aq_rd_d   = aq_rd_q + PTR_W'(1);
      fifo_wr_d = fifo_wr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      fifo_rd_d = fifo_rd_q + PTR_W'(1);
    end
    if (jump_flag_i) begin
      pc_d       = {jump_addr_i[31:2], 2'b00};
      disc_cnt_d = disc_cnt_q + out_cnt_q - CNT_W'(resp_known);
      out_cnt_d  = '0;
      fifo_cnt_d = '0;
      aq_wr_d    = '0;
      aq_rd_d    = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_ADDR;
      run_q      <= 1'b0;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      fifo_cnt_q <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      run_q      <= run_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
    end
  end

  // Storage arrays need no reset: their contents are only qualified by the counters.
  always_ff @(posedge clk) begin
    if (grant) begin
      aq_addr_q[aq_wr_q] <= pc_q;
    end
    if (resp_take) begin
      fifo_addr_q[fifo_wr_q] <= aq_addr_q[aq_rd_q];
      fifo_inst_q[fifo_wr_q] <= ibus_rdata_i;
    end
  end

  // Outputs derived from registered state; the empty FIFO presents a NOP.
  always_comb begin
    inst_valid_o = (fifo_cnt_q != '0);
    ibus_addr_o  = pc_q;
    inst_o       = inst_valid_o ? fifo_inst_q[fifo_rd_q] : INST_NOP;
    inst_addr_o  = inst_valid_o ? fifo_addr_q[fifo_rd_q] : ZERO_WORD;
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed bench for ifu_prefetch with an in-order
// fixed-latency memory model. Expected values are hand-derived per cycle.
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [2:0]  HOLD_IF    = 3'd2;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  int          cyc;
  int          mem_lat;
  int          tests_run;
  int          fail_count;
  logic [31:0] exp_pop;

  ifu_prefetch #(
    .FIFO_DEPTH(2),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive the per-cycle inputs just after a rising edge, then settle to the falling edge.
  task automatic applyStimulus(input logic jmp, input logic [31:0] ja,
                               input logic [2:0] hold, input logic gnt);
    jump_flag_i = jmp;
    jump_addr_i = ja;
    hold_flag_i = hold;
    ibus_gnt_i  = gnt;
    @(negedge clk);
  endtask

  task automatic checkCycle(input string tag, input logic er, input logic [31:0] ea,
                            input logic ev, input logic [31:0] eia);
    checkOutput({tag, ".req"}, 32'(ibus_req_o), 32'(er));
    checkOutput({tag, ".addr"}, ibus_addr_o, ea);
    checkOutput({tag, ".valid"}, 32'(inst_valid_o), 32'(ev));
    if (ev) begin
      checkOutput({tag, ".iaddr"}, inst_addr_o, eia);
    end else begin
      checkOutput({tag, ".nop"}, inst_o, NOP);
      checkOutput({tag, ".zaddr"}, inst_addr_o, 32'h0);
    end
  endtask

  // Close out the cycle: data/order checks, memory model update, next response.
  task automatic advance();
    pend_t e;
    if (inst_valid_o) begin
      checkOutput("inst_data", inst_o, data_of(inst_addr_o));
    end
    if (inst_valid_o && (hold_flag_i < HOLD_IF) && !jump_flag_i) begin
      checkOutput("pop_order", inst_addr_o, exp_pop);
      exp_pop = exp_pop + 32'd4;
    end
    if (jump_flag_i) begin
      exp_pop = {jump_addr_i[31:2], 2'b00};
    end
    if (rst && ibus_req_o && ibus_gnt_i) begin
      e.addr = ibus_addr_o;
      e.due  = cyc + mem_lat;
      pend_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    if ((pend_q.size() > 0) && (pend_q[0].due <= cyc)) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = data_of(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic runCycle(input string tag, input logic jmp, input logic [31:0] ja,
                          input logic [2:0] hold, input logic gnt,
                          input logic er, input logic [31:0] ea,
                          input logic ev, input logic [31:0] eia);
    applyStimulus(jmp, ja, hold, gnt);
    checkCycle(tag, er, ea, ev, eia);
    advance();
  endtask

  initial begin
    tests_run     = 0;
    fail_count    = 0;
    cyc           = 0;
    mem_lat       = 1;
    exp_pop       = RESET_ADDR;
    rst           = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'h0;

    // Reset values, then release and stream from a zero-wait memory.
    applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
    checkCycle("reset", 1'b0, RESET_ADDR, 1'b0, 32'h0);
    rst = 1'b1;
    advance();
    for (int k = 0; k < 8; k++) begin
      runCycle($sformatf("stream%0d", k), 1'b0, 32'h0, 3'd0, 1'b1,
               1'b1, 32'(4 * k), (k >= 2), 32'(4 * k) - 32'd8);
    end

    // Hold: FIFO fills, request drops, head stays; then resume with no gap.
    for (int k = 0; k < 5; k++) begin
      runCycle($sformatf("hold%0d", k), 1'b0, 32'h0, 3'd2, 1'b1,
               1'b0, 32'h20, 1'b1, 32'h18);
    end
    for (int k = 0; k < 4; k++) begin
      runCycle($sformatf("resume%0d", k), 1'b0, 32'h0, 3'd0, 1'b1,
               1'b1, 32'h20 + 32'(4 * k), 1'b1, 32'h18 + 32'(4 * k));
    end

    // Grant withheld: request and address stay put, one push on the grant.
    runCycle("gnt0", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h30, 1'b1, 32'h28);
    runCycle("gnt1", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h30, 1'b1, 32'h2C);
    runCycle("gnt2", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
    runCycle("gnt3", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
    runCycle("gnt4", 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 32'h30, 1'b0, 32'h0);
    runCycle("gnt5", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h34, 1'b0, 32'h0);
    runCycle("gnt6", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h34, 1'b1, 32'h30);
    runCycle("gnt7", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h34, 1'b0, 32'h0);

    // Jump to 0x102 with two requests outstanding on a 3-cycle memory.
    mem_lat = 3;
    runCycle("jmpA0", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h34,  1'b0, 32'h0);
    runCycle("jmpA1", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h38,  1'b0, 32'h0);
    runCycle("jmpA2", 1'b1, 32'h102, 3'd0, 1'b1, 1'b0, 32'h3C,  1'b0, 32'h0);
    runCycle("jmpA3", 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
    runCycle("jmpA4", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    runCycle("jmpA5", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0);
    runCycle("jmpA6", 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h108, 1'b0, 32'h0);
    runCycle("jmpA7", 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h108, 1'b0, 32'h0);
    runCycle("jmpA8", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100);
    runCycle("jmpA9", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104);

    // Jump in the same cycle as a response, one more request still outstanding.
    runCycle("jmpB0", 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h110, 1'b0, 32'h0);
    runCycle("jmpB1", 1'b1, 32'h200, 3'd0, 1'b1, 1'b0, 32'h110, 1'b0, 32'h0);
    runCycle("jmpB2", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    runCycle("jmpB3", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0);
    runCycle("jmpB4", 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h208, 1'b0, 32'h0);
    runCycle("jmpB5", 1'b0, 32'h0,   3'd0, 1'b1, 1'b0, 32'h208, 1'b0, 32'h0);
    runCycle("jmpB6", 1'b0, 32'h0,   3'd0, 1'b0, 1'b1, 32'h208, 1'b1, 32'h200);
    runCycle("jmpB7", 1'b0, 32'h0,   3'd0, 1'b0, 1'b1, 32'h208, 1'b1, 32'h204);

    // Jump from a zero-wait stream: request in N+1, target on the output in N+3.
    mem_lat = 1;
    runCycle("jmpC0", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h208, 1'b0, 32'h0);
    runCycle("jmpC1", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h20C, 1'b0, 32'h0);
    runCycle("jmpC2", 1'b1, 32'h300, 3'd0, 1'b1, 1'b0, 32'h210, 1'b1, 32'h208);
    runCycle("jmpC3", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    runCycle("jmpC4", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h304, 1'b0, 32'h0);
    runCycle("jmpC5", 1'b0, 32'h0,   3'd0, 1'b1, 1'b1, 32'h308, 1'b1, 32'h300);
    runCycle("jmpC6", 1'b0, 32'h0,   3'd2, 1'b1, 1'b0, 32'h30C, 1'b1, 32'h304);

    // FIFO full under hold, then reset asserted mid-cycle.
    applyStimulus(1'b0, 32'h0, 3'd2, 1'b1);
    checkCycle("full", 1'b0, 32'h30C, 1'b1, 32'h304);
    #2 rst = 1'b0;
    #1;
    checkCycle("midrst", 1'b0, RESET_ADDR, 1'b0, 32'h0);
    pend_q.delete();
    ibus_rvalid_i = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
    checkCycle("inrst", 1'b0, RESET_ADDR, 1'b0, 32'h0);
    rst     = 1'b1;
    exp_pop = RESET_ADDR;
    advance();
    for (int k = 0; k < 4; k++) begin
      runCycle($sformatf("restart%0d", k), 1'b0, 32'h0, 3'd0, 1'b1,
               1'b1, RESET_ADDR + 32'(4 * k), (k >= 2), RESET_ADDR + 32'(4 * k) - 32'd8);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Instruction-fetch front end: it owns the PC and issues fetch requests on the instruction bus. Returned words are buffered with their addresses in a small FIFO, and the FIFO head is presented as `inst_o`/`inst_addr_o` to the IF/ID pipeline register (`ifu_ifetch`). Jumps redirect the PC, flush the FIFO and discard in-flight responses. Pipeline hold stops consumption without losing fetched instructions.

## Interface
- `FIFO_DEPTH`, 2: buffer entries; also the cap on outstanding bus requests (≥2, power of two).
- `RESET_ADDR`, 32'h0000_0000: PC after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `jump_flag_i` in 1: redirect request this cycle.
- `jump_addr_i` in 32: redirect target; bits [1:0] are forced to 0.
- `hold_flag_i` in `Hold_Flag_Bus`: pipeline hold; fetch output is stalled when value ≥ `Hold_If`.
- `ibus_req_o` out 1: fetch request valid.
- `ibus_addr_o` out 32: fetch address (= PC).
- `ibus_gnt_i` in 1: request accepted this cycle.
- `ibus_rvalid_i` in 1: response valid; in-order, at least 1 cycle after its grant.
- `ibus_rdata_i` in 32: response instruction word.
- `inst_o` out 32: FIFO head instruction; `INST_NOP` when empty.
- `inst_addr_o` out 32: FIFO head address; `ZeroWord` when empty.
- `inst_valid_o` out 1: FIFO non-empty.

## Operation
- State:
  - `pc` (32)
  - `out_cnt`: outstanding granted requests, 0..DEPTH
  - `disc_cnt`: responses still to be dropped, 0..DEPTH
  - address queue (DEPTH×32) for granted-but-unanswered requests
  - data FIFO (DEPTH × {addr, inst}) with `fifo_cnt`, read/write pointers that wrap modulo DEPTH
- Pop: `inst_valid_o && hold_flag_i < Hold_If && !jump_flag_i`.
- Issue: `ibus_req_o = !jump_flag_i && (out_cnt + disc_cnt + fifo_cnt - pop) < DEPTH`.
  - `ibus_addr_o = pc`.
  - Request and address stay stable until granted, unless a jump withdraws them.
- Grant (`ibus_req_o && ibus_gnt_i`): push `pc` to the address queue, `pc <= pc + 4` (32-bit wrap), `out_cnt++`.
- Response:
  - If `disc_cnt > 0`: `disc_cnt--` and the data is dropped.
  - Otherwise: pop the address queue, `out_cnt--`, push {addr, rdata} into the FIFO.
  - The FIFO cannot overflow because issue credits reserve the slot.
- Simultaneous grant, response and pop in one cycle: all three counters update consistently; net changes are summed.
- Jump (highest priority over hold, pop and issue):
  - `pc <= {jump_addr_i[31:2], 2'b00}`.
  - FIFO and address queue cleared.
  - `disc_cnt <= disc_cnt + out_cnt - (response this cycle ? 1 : 0)`.
  - `out_cnt <= 0`.
  - A response arriving in the jump cycle is dropped.
- `ibus_rvalid_i` with no outstanding or discard count is a protocol violation; the design ignores it.
- Reset (asynchronous, any time, including mid-burst):
  - `pc = RESET_ADDR`; all counters and pointers 0.
  - `ibus_req_o = 0`, `inst_valid_o = 0`, `inst_o = INST_NOP`, `inst_addr_o = ZeroWord`.
  - Responses to pre-reset requests are the bus's responsibility to squash.

## Timing
- First request is asserted in the first cycle after `rst` deasserts, with `ibus_addr_o = RESET_ADDR`.
- Response to output: data captured on the `rvalid` edge; `inst_valid_o` is high the next cycle. There is no combinational bypass.
- Minimum grant→`inst_valid_o` latency is 2 cycles with a 1-cycle memory.
- Throughput: the pop term in the credit equation allows 1 instruction/cycle sustained with DEPTH=2 and a 1-cycle zero-wait memory.
- Jump in cycle N:
  - `ibus_req_o = 0` in N.
  - Request to the target in N+1.
  - Earliest target instruction on `inst_o` in N+3.
  - `inst_valid_o = 0` from N+1 until then.
- Hold: FIFO head and outputs stay stable while held. Fetch continues until credits are exhausted, then `ibus_req_o` drops.
- All outputs are registered or derived from registered state, except `ibus_req_o`, which also depends on `jump_flag_i` and `hold_flag_i`.

## Test plan
- Reset release, zero-wait memory always granting, no hold:
  - `ibus_addr_o` is 0x0, 0x4, 0x8… on consecutive cycles.
  - `inst_valid_o` rises 2 cycles after the first grant.
  - `inst_addr_o` advances by 4 every cycle.
- Hold ≥ `Hold_If` for 5 cycles mid-stream (DEPTH=2):
  - FIFO fills to 2 and `ibus_req_o` drops.
  - Head stays fixed at, e.g., 0x10.
  - After release, 0x10, 0x14… continue with no gap or duplicate.
- Jump to 0x0000_0102 with 2 requests outstanding on a 3-cycle-latency memory:
  - The next request address is 0x100.
  - Both stale responses are dropped.
  - The first valid output is addr 0x100 with its data.
- Jump in the same cycle as a response and a grant:
  - The response is dropped and `disc_cnt` ends at 1 (the granted request).
  - No stale instruction ever appears with `inst_valid_o` high.
- `ibus_gnt_i` held low for 4 cycles: `ibus_req_o` and `ibus_addr_o` stay stable throughout; exactly one push occurs on the grant.
- Assert `rst` low mid-stream with FIFO full: all outputs take their reset values immediately; restart from `RESET_ADDR`.
